// File: rtl/depth_tested_pixel_writer_pkg.sv
// depth_tested_pixel_writer_pkg: pixel stream types and fixed-point depth format shared by the writer.
package depth_tested_pixel_writer_pkg;
   typedef logic [11:0] color_t;
   typedef logic signed [15:0] fixed;
   localparam fixed FB_CLEAR_DEPTH = 16'sh7fff;
   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
   } coordinate_t;
   typedef struct packed {
      coordinate_t coordinate;
      fixed depth;
      color_t color;
      logic covered;
   } pixel_data_t;
   typedef struct packed {
      logic last;
   } pixel_metadata_t;
endpackage

// File: rtl/depth_tested_pixel_writer_if.sv
// depth_tested_pixel_writer_if: ready/valid pixel stream from the rasterizer.
interface depth_tested_pixel_writer_if;
   import depth_tested_pixel_writer_pkg::*;
   logic ready;
   logic valid;
   pixel_data_t data;
   pixel_metadata_t metadata;
   modport master(input ready, output valid, data, metadata);
   modport slave(output ready, input valid, data, metadata);
endinterface

// File: rtl/depth_tested_pixel_writer_depth_buffer.sv
// depth_tested_pixel_writer_depth_buffer: single-port depth RAM with one-cycle registered read.
module depth_tested_pixel_writer_depth_buffer
   import depth_tested_pixel_writer_pkg::*;
#(
   parameter int ENTRIES = 4096,
   parameter int ADDR_W = 12
) (
   input  logic clk,
   input  logic we,
   input  logic [ADDR_W-1:0] addr,
   input  fixed wdata,
   output fixed rdata
);
   fixed mem [ENTRIES];
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end
endmodule

// File: rtl/depth_tested_pixel_writer.sv
// depth_tested_pixel_writer: depth-tests rasterized pixels, writes passing ones to the
// framebuffer, and sweeps a full-frame clear on request.
module depth_tested_pixel_writer
   import depth_tested_pixel_writer_pkg::*;
#(
   parameter int VIEWPORT_WIDTH = 64,
   parameter int VIEWPORT_HEIGHT = 64,
   localparam int ADDR_W = $clog2(VIEWPORT_WIDTH * VIEWPORT_HEIGHT)
) (
   input  logic clk,
   input  logic rst,
   depth_tested_pixel_writer_if.slave pixel_data_s,
   input  logic clear_start,
   input  color_t clear_color,
   output logic busy,
   output logic triangle_done,
   output logic fb_write_en,
   output logic [ADDR_W-1:0] fb_write_addr,
   output color_t fb_write_data
);
   localparam logic [1:0] S_IDLE = 2'd0, S_CLEAR = 2'd1, S_READ = 2'd2, S_TEST = 2'd3;
   localparam int PIXELS = VIEWPORT_WIDTH * VIEWPORT_HEIGHT;
   logic [1:0] state;
   logic clear_pending, last_r, handshake, in_range, ram_we;
   logic [ADDR_W-1:0] addr, beat_addr, ram_addr;
   fixed pix_depth, ram_rdata, ram_wdata;
   color_t pix_color, clear_color_r;
   assign pixel_data_s.ready = state == S_IDLE && !clear_pending && !clear_start && !rst;
   assign handshake = pixel_data_s.ready && pixel_data_s.valid;
   assign in_range = int'(pixel_data_s.data.coordinate.x) < VIEWPORT_WIDTH &&
                     int'(pixel_data_s.data.coordinate.y) < VIEWPORT_HEIGHT;
   assign beat_addr = ADDR_W'(int'(pixel_data_s.data.coordinate.y) * VIEWPORT_WIDTH +
                              int'(pixel_data_s.data.coordinate.x));
   // The depth read is launched on the accept edge so the compare resolves in READ
   // and the framebuffer strobe can still be a registered output in TEST.
   assign ram_addr = state == S_IDLE ? beat_addr : addr;
   assign ram_we = !rst && (state == S_CLEAR || (state == S_TEST && fb_write_en));
   assign ram_wdata = state == S_CLEAR ? FB_CLEAR_DEPTH : pix_depth;
   assign busy = state != S_IDLE;
   depth_tested_pixel_writer_depth_buffer #(.ENTRIES(PIXELS), .ADDR_W(ADDR_W)) depth_buffer (
      .clk(clk),
      .we(ram_we),
      .addr(ram_addr),
      .wdata(ram_wdata),
      .rdata(ram_rdata)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         clear_pending <= 1'b0;
         triangle_done <= 1'b0;
         fb_write_en <= 1'b0;
         fb_write_addr <= '0;
         fb_write_data <= '0;
      end else begin
         triangle_done <= 1'b0;
         fb_write_en <= 1'b0;
         if (clear_start && state != S_IDLE) clear_pending <= 1'b1;
         if (state == S_IDLE) begin
            if (clear_start || clear_pending) begin
               state <= S_CLEAR;
               addr <= '0;
               clear_color_r <= clear_color;
            end else if (handshake) begin
               addr <= beat_addr;
               pix_depth <= pixel_data_s.data.depth;
               pix_color <= pixel_data_s.data.color;
               last_r <= pixel_data_s.metadata.last;
               if (pixel_data_s.data.covered && in_range) state <= S_READ;
               else triangle_done <= pixel_data_s.metadata.last;
            end
         end else if (state == S_CLEAR) begin
            fb_write_en <= 1'b1;
            fb_write_addr <= addr;
            fb_write_data <= clear_color_r;
            addr <= addr + 1'b1;
            if (addr == ADDR_W'(PIXELS - 1)) begin
               state <= S_IDLE;
               clear_pending <= 1'b0;
            end
         end else if (state == S_READ) begin
            fb_write_en <= pix_depth < ram_rdata;
            fb_write_addr <= addr;
            fb_write_data <= pix_color;
            state <= S_TEST;
         end else begin
            triangle_done <= last_r;
            state <= S_IDLE;
         end
      end
   end
endmodule
